// File: rtl/frame_streamer_pkg.sv
// Shared definitions for the frame streamer and the histogram engine.
package frame_streamer_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Bits needed to index n items.
  // Never returns less than 1, so a degenerate size of 1 still gets a real vector.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Pixel stream towards the video/DMA sink: valid/ready with frame markers.
interface frame_streamer_if;
  import frame_streamer_pkg::*;

  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/frame_streamer_sync_fifo.sv
// Small first-word-fall-through FIFO holding prefetched pixels.
module sync_fifo
  import frame_streamer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Advance pointers and occupancy for this cycle's push/pop.
  always_comb begin
    // NOTE: every _d is given its hold value first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // The issue credit accounting upstream must make these impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $error("sync_fifo: push into full fifo");
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
    else $error("sync_fifo: pop from empty fifo");

endmodule

// File: rtl/frame_streamer.sv
// Streams a finished frame out of the output RAM in raster order,
// prefetching through a credit-limited FIFO so RAM latency and sink stalls are absorbed.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int W               = 64,
  parameter int H               = 64,
  parameter int TOTAL_PIXEL_BIT = clog2_min1(W * H),
  parameter int RD_LAT          = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
  input  logic [PIX_W-1:0]           rd_data,
  frame_streamer_if.master           m_if
);

  localparam int NPIX  = W * H;
  localparam int X_W   = clog2_min1(W);
  localparam int Y_W   = clog2_min1(H);
  localparam int RC_W  = TOTAL_PIXEL_BIT + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = clog2_min1(RD_LAT + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              m_valid, pop, push, issue, credit_ok;

  // Beats come only from the FIFO and only while streaming; ready never feeds back into valid.
  assign m_valid = (state_q == ST_STREAM) && !fifo_empty;
  assign pop     = m_valid && m_if.m_ready;
  assign push    = vpipe_q[RD_LAT-1];

  // Slots already promised (stored + in flight) must leave room for one more read.
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));
  assign issue     = (state_q == ST_STREAM) && (rd_cnt_q < RC_W'(NPIX)) && credit_ok;

  assign rd_en   = issue;
  assign rd_addr = issue ? rd_cnt_q[TOTAL_PIXEL_BIT-1:0] : '0;
  assign busy    = (state_q == ST_STREAM);
  assign done    = (state_q == ST_DONE);

  // Markers come from the raster counters; everything is forced to 0 when no beat is offered.
  assign m_if.m_valid = m_valid;
  assign m_if.m_data  = m_valid ? fifo_head : '0;
  assign m_if.m_sof   = m_valid && (x_q == '0) && (y_q == '0);
  assign m_if.m_eol   = m_valid && (x_q == X_LAST);
  assign m_if.m_eof   = m_valid && (x_q == X_LAST) && (y_q == Y_LAST);

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state: frame sequencing, read counter, latency tags and raster position.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    inflight_d = inflight_q + IF_W'(issue) - IF_W'(push);
    vpipe_d    = RD_LAT'({vpipe_q, issue});
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_STREAM;
          rd_cnt_d   = '0;
          x_d        = '0;
          y_d        = '0;
          inflight_d = '0;
        end
      end
      ST_STREAM: begin
        if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (pop) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            if (y_q == Y_LAST) state_d = ST_DONE;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= '0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      vpipe_q    <= vpipe_d;
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: three instances (4x4 lat 1, 4x4 lat 2, 1x1 lat 1),
// a raster-order beat model checked every cycle, and directed frame scenarios.
module tb_frame_streamer;
  import frame_streamer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_s [3];
  logic ready_s [3];

  int n_checks = 0;
  int n_errors = 0;

  logic       busy_a, done_a, rd_en_a, busy_b, done_b, rd_en_b, busy_c, done_c, rd_en_c;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [0:0] rd_addr_c;
  logic [7:0] rd_data_a, rd_data_b0, rd_data_b, rd_data_c;

  frame_streamer_if if_a ();
  frame_streamer_if if_b ();
  frame_streamer_if if_c ();

  assign if_a.m_ready = ready_s[0];
  assign if_b.m_ready = ready_s[1];
  assign if_c.m_ready = ready_s[2];

  frame_streamer #(.W(4), .H(4), .RD_LAT(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .m_if(if_a));
  frame_streamer #(.W(4), .H(4), .RD_LAT(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .m_if(if_b));
  frame_streamer #(.W(1), .H(1), .RD_LAT(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .m_if(if_c));

  // RAM models: RAM[a]=a for the 4x4 frames, RAM[0]=0xA5 for the 1x1 frame.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= 8'(rd_addr_a);
    if (rd_en_b) rd_data_b0 <= 8'(rd_addr_b);
    rd_data_b <= rd_data_b0;
    if (rd_en_c) rd_data_c <= (rd_addr_c == 1'b0) ? 8'hA5 : 8'h00;
  end

  // Uniform per-instance views so tasks can take an instance index.
  logic       valid_s [3], sof_s [3], eol_s [3], eof_s [3], busy_s [3], done_s [3], rd_en_s [3];
  logic [7:0] data_s [3], rd_addr_s [3];
  always_comb begin
    valid_s[0] = if_a.m_valid; data_s[0] = if_a.m_data; sof_s[0] = if_a.m_sof;
    eol_s[0] = if_a.m_eol; eof_s[0] = if_a.m_eof;
    valid_s[1] = if_b.m_valid; data_s[1] = if_b.m_data; sof_s[1] = if_b.m_sof;
    eol_s[1] = if_b.m_eol; eof_s[1] = if_b.m_eof;
    valid_s[2] = if_c.m_valid; data_s[2] = if_c.m_data; sof_s[2] = if_c.m_sof;
    eol_s[2] = if_c.m_eol; eof_s[2] = if_c.m_eof;
    busy_s[0] = busy_a; done_s[0] = done_a; rd_en_s[0] = rd_en_a; rd_addr_s[0] = 8'(rd_addr_a);
    busy_s[1] = busy_b; done_s[1] = done_b; rd_en_s[1] = rd_en_b; rd_addr_s[1] = 8'(rd_addr_b);
    busy_s[2] = busy_c; done_s[2] = done_c; rd_en_s[2] = rd_en_c; rd_addr_s[2] = 8'(rd_addr_c);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: beat k of a WxH frame carries RAM[k]; sof at k=0, eol when k%W==W-1, eof at k=W*H-1.
  function automatic logic [7:0] exp_pix(input int inst, input int k);
    return (inst == 2) ? 8'hA5 : 8'(k);
  endfunction

  int k [3] = '{0, 0, 0};

  // Compare process: every offered beat must match the model's next beat; stalls hold k.
  always @(negedge clk) begin
    int w, np;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) k[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        w  = (i == 2) ? 1 : 4;
        np = (i == 2) ? 1 : 16;
        if (valid_s[i]) begin
          check($sformatf("u%0d beat%0d data", i, k[i]), 32'(data_s[i]), 32'(exp_pix(i, k[i])));
          check($sformatf("u%0d beat%0d sof", i, k[i]), 32'(sof_s[i]), 32'(k[i] == 0));
          check($sformatf("u%0d beat%0d eol", i, k[i]), 32'(eol_s[i]), 32'((k[i] % w) == w - 1));
          check($sformatf("u%0d beat%0d eof", i, k[i]), 32'(eof_s[i]), 32'(k[i] == np - 1));
          if (ready_s[i]) k[i] = (k[i] == np - 1) ? 0 : k[i] + 1;
        end
      end
      check("u0 fifo+inflight<=4", 32'((int'(u_a.fifo_count) + int'(u_a.inflight_q)) <= 4), 32'd1);
      check("u1 fifo+inflight<=4", 32'((int'(u_b.fifo_count) + int'(u_b.inflight_q)) <= 4), 32'd1);
    end
  end

  task automatic check_all_zero(input int inst, input string tag);
    check($sformatf("%s u%0d m_valid", tag, inst), 32'(valid_s[inst]), 0);
    check($sformatf("%s u%0d m_data", tag, inst), 32'(data_s[inst]), 0);
    check($sformatf("%s u%0d sof/eol/eof", tag, inst),
          32'({sof_s[inst], eol_s[inst], eof_s[inst]}), 0);
    check($sformatf("%s u%0d busy/done", tag, inst), 32'({busy_s[inst], done_s[inst]}), 0);
    check($sformatf("%s u%0d rd_en", tag, inst), 32'(rd_en_s[inst]), 0);
    check($sformatf("%s u%0d rd_addr", tag, inst), 32'(rd_addr_s[inst]), 0);
  endtask

  // Start one frame and follow it to done; leaves start high.
  task automatic run_frame(input int inst, input bit rnd, input int exp_first, input int np,
                           input logic [15:0] exp_eol, input int exp_sum);
    int cyc, first, last, beats, sum, done_cyc;
    logic [15:0] sof_m, eol_m, eof_m;
    cyc = 0; first = -1; last = -1; beats = 0; sum = 0; done_cyc = -1;
    sof_m = '0; eol_m = '0; eof_m = '0;
    @(posedge clk); #1 start_s[inst] = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(posedge clk); #1;
      if (rnd) ready_s[inst] = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("u%0d first rd_en", inst), 32'(rd_en_s[inst]), 1);
        check($sformatf("u%0d first rd_addr", inst), 32'(rd_addr_s[inst]), 0);
        check($sformatf("u%0d busy after start", inst), 32'(busy_s[inst]), 1);
      end
      if (valid_s[inst]) begin
        if (first < 0) first = cyc;
        if (ready_s[inst]) begin
          if (beats < 16) begin
            sof_m[beats] = sof_s[inst]; eol_m[beats] = eol_s[inst]; eof_m[beats] = eof_s[inst];
          end
          sum += int'(data_s[inst]);
          beats++;
          last = cyc;
        end
      end
      if (done_s[inst]) done_cyc = cyc;
    end
    ready_s[inst] = 1'b1;
    check($sformatf("u%0d first m_valid cycle", inst), 32'(first), 32'(exp_first));
    check($sformatf("u%0d beat count", inst), 32'(beats), 32'(np));
    if (!rnd) check($sformatf("u%0d no gaps", inst), 32'(last - first), 32'(np - 1));
    check($sformatf("u%0d done cycle", inst), 32'(done_cyc), 32'(last + 1));
    check($sformatf("u%0d busy at done", inst), 32'(busy_s[inst]), 0);
    check($sformatf("u%0d sof mask", inst), 32'(sof_m), 32'h1);
    check($sformatf("u%0d eol mask", inst), 32'(eol_m), 32'(exp_eol));
    check($sformatf("u%0d eof mask", inst), 32'(eof_m), 32'(1 << (np - 1)));
    check($sformatf("u%0d data sum", inst), 32'(sum), 32'(exp_sum));
  endtask

  // With start still high, done must hold and no new frame may begin; then drop start.
  task automatic hold_and_release(input int inst, input int n);
    repeat (n) begin
      @(negedge clk);
      check($sformatf("u%0d done held", inst), 32'(done_s[inst]), 1);
      check($sformatf("u%0d no restart valid", inst), 32'(valid_s[inst]), 0);
      check($sformatf("u%0d no restart rd_en", inst), 32'(rd_en_s[inst]), 0);
    end
    @(posedge clk); #1 start_s[inst] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("u%0d done cleared", inst), 32'(done_s[inst]), 0);
    check($sformatf("u%0d idle busy", inst), 32'(busy_s[inst]), 0);
  endtask

  initial begin
    int beats, cyc;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4x4, latency 1, sink always ready; start kept high through DONE.
    run_frame(0, 1'b0, 3, 16, 16'h8888, 120);
    hold_and_release(0, 6);

    // Same frame under 30% stalls: model checks order and stability on every cycle.
    run_frame(0, 1'b1, 3, 16, 16'h8888, 120);
    hold_and_release(0, 2);

    // Latency 2.
    run_frame(1, 1'b0, 4, 16, 16'h8888, 120);
    hold_and_release(1, 2);

    // Reset while beat 5 is on the bus.
    @(posedge clk); #1 start_s[0] = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 5 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (valid_s[0] && ready_s[0]) beats++;
    end
    @(posedge clk);
    @(negedge clk);
    check("u0 beat before reset", 32'(data_s[0]), 32'd5);
    #2 rst_n = 1'b0;
    start_s[0] = 1'b0;
    #1 check_all_zero(0, "midframe reset");
    @(negedge clk); #2 rst_n = 1'b1;
    run_frame(0, 1'b0, 3, 16, 16'h8888, 120);
    hold_and_release(0, 2);

    // Degenerate 1x1 frame.
    run_frame(2, 1'b0, 3, 1, 16'h0001, 165);
    hold_and_release(2, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
